// File: rtl/sr_fde_pipeline_pkg.sv
// Shared constants, ALU codes and decode control bundle for the FDE pipeline.
package sr_fde_pipeline_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_SRL  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_SUB  = 3'b100
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    wd_src;
        logic    alu_src;
        logic    branch;
        logic    cond_zero;
        alu_op_e alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Control bundle for a register-register ALU instruction.
    function automatic ctrl_t rtype_ctrl(input alu_op_e op);
        ctrl_t c;
        c             = CTRL_BUBBLE;
        c.reg_write   = 1'b1;
        c.wd_src      = 1'b1;
        c.alu_control = op;
        return c;
    endfunction

endpackage

// File: rtl/sr_fde_pipeline_alu.sv
// Combinational ALU used by the execute stage.
module sr_alu
    import sr_fde_pipeline_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result_c
);

    // Select the operation; add/sub wrap naturally at XLEN bits.
    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_OR:   result_c = a | b;
            ALU_SRL:  result_c = a >> b[4:0];
            ALU_SLTU: result_c = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/sr_fde_pipeline.sv
// Three-stage fetch/decode/execute pipeline slice with stall and flush.
module sr_fde_pipeline
    import sr_fde_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [XLEN-1:0]   pc_i,
    output logic [XLEN-1:0]   imAddr,
    input  logic [XLEN-1:0]   imData,
    output logic [XLEN-1:0]   pcPlus4_f_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic              branch_d_o,
    input  logic [XLEN-1:0]   srcA_i,
    input  logic [XLEN-1:0]   srcB_i,
    output logic              wdSrc_o,
    output logic              regWrite_o,
    output logic              branch_o,
    output logic              condZero_o,
    output logic              aluZero_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   aluResult_o,
    output logic [XLEN-1:0]   immU_o,
    output logic [XLEN-1:0]   pcBranch_o,
    output logic [XLEN-1:0]   pcPlus4_o
);

    logic [XLEN-1:0]   instr_f;
    logic [XLEN-1:0]   pc_f;
    logic [XLEN-1:0]   pc_plus4_f;

    ctrl_t             ctrl_dec;
    logic [XLEN-1:0]   imm_i_dec;
    logic [XLEN-1:0]   imm_u_dec;
    logic [XLEN-1:0]   imm_b_dec;

    ctrl_t             ctrl_d;
    logic [REG_AW-1:0] rd_d;
    logic [XLEN-1:0]   imm_i_d;
    logic [XLEN-1:0]   imm_u_d;
    logic [XLEN-1:0]   pc_branch_d;
    logic [XLEN-1:0]   pc_plus4_d;

    logic [XLEN-1:0]   alu_b_c;
    logic [XLEN-1:0]   alu_result_c;

    assign imAddr      = pc_i;
    assign pcPlus4_f_o = pc_plus4_f;

    // Fetch register: capture the addressed word unless the hazard unit stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_f    <= '0;
            pc_f       <= RESET_PC;
            pc_plus4_f <= RESET_PC + 32'd4;
        end else if (!freeze) begin
            instr_f    <= imData;
            pc_f       <= pc_i;
            pc_plus4_f <= pc_i + 32'd4;
        end
    end

    assign imm_i_dec = {{20{instr_f[31]}}, instr_f[31:20]};
    assign imm_u_dec = {instr_f[31:12], 12'b0};
    assign imm_b_dec = {{19{instr_f[31]}}, instr_f[31], instr_f[7],
                        instr_f[30:25], instr_f[11:8], 1'b0};

    // Instruction decode; anything not recognised stays a bubble.
    always_comb begin
        ctrl_dec = CTRL_BUBBLE;
        case (instr_f[6:0])
            OP_RTYPE: begin
                if (instr_f[31:25] == F7_SUB) begin
                    if (instr_f[14:12] == F3_ADD_SUB) ctrl_dec = rtype_ctrl(ALU_SUB);
                end else if (instr_f[31:25] == F7_BASE) begin
                    case (instr_f[14:12])
                        F3_ADD_SUB: ctrl_dec = rtype_ctrl(ALU_ADD);
                        F3_OR:      ctrl_dec = rtype_ctrl(ALU_OR);
                        F3_SRL:     ctrl_dec = rtype_ctrl(ALU_SRL);
                        F3_SLTU:    ctrl_dec = rtype_ctrl(ALU_SLTU);
                        default:    ctrl_dec = CTRL_BUBBLE;
                    endcase
                end
            end
            OP_IMM: begin
                if (instr_f[14:12] == F3_ADDI) begin
                    ctrl_dec         = rtype_ctrl(ALU_ADD);
                    ctrl_dec.alu_src = 1'b1;
                end
            end
            OP_LUI: begin
                ctrl_dec.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                if (instr_f[14:12] == F3_BEQ || instr_f[14:12] == F3_BNE) begin
                    ctrl_dec.branch      = 1'b1;
                    ctrl_dec.alu_control = ALU_SUB;
                    ctrl_dec.cond_zero   = (instr_f[14:12] == F3_BEQ);
                end
            end
            default: ctrl_dec = CTRL_BUBBLE;
        endcase
    end

    // Decode register: a stall injects a bubble by killing the controls only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_d      <= CTRL_BUBBLE;
            rs1_o       <= '0;
            rs2_o       <= '0;
            rd_d        <= '0;
            imm_i_d     <= '0;
            imm_u_d     <= '0;
            pc_branch_d <= '0;
            pc_plus4_d  <= '0;
        end else begin
            ctrl_d      <= freeze ? CTRL_BUBBLE : ctrl_dec;
            rs1_o       <= instr_f[19:15];
            rs2_o       <= instr_f[24:20];
            rd_d        <= instr_f[11:7];
            imm_i_d     <= imm_i_dec;
            imm_u_d     <= imm_u_dec;
            pc_branch_d <= pc_f + imm_b_dec;
            pc_plus4_d  <= pc_plus4_f;
        end
    end

    assign branch_d_o = ctrl_d.branch;
    assign alu_b_c    = ctrl_d.alu_src ? imm_i_d : srcB_i;

    sr_alu u_alu (
        .a        (srcA_i),
        .b        (alu_b_c),
        .op       (ctrl_d.alu_control),
        .result_c (alu_result_c)
    );

    // Execute register: never stalls, rd=0 writes are left to the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluResult_o <= '0;
            aluZero_o   <= 1'b0;
            wdSrc_o     <= 1'b0;
            regWrite_o  <= 1'b0;
            branch_o    <= 1'b0;
            condZero_o  <= 1'b0;
            rd_o        <= '0;
            immU_o      <= '0;
            pcBranch_o  <= '0;
            pcPlus4_o   <= '0;
        end else begin
            aluResult_o <= alu_result_c;
            aluZero_o   <= (alu_result_c == '0);
            wdSrc_o     <= ctrl_d.wd_src;
            regWrite_o  <= ctrl_d.reg_write;
            branch_o    <= ctrl_d.branch;
            condZero_o  <= ctrl_d.cond_zero;
            rd_o        <= rd_d;
            immU_o      <= imm_u_d;
            pcBranch_o  <= pc_branch_d;
            pcPlus4_o   <= pc_plus4_d;
        end
    end

endmodule

// File: tb/tb_sr_fde_pipeline.sv
// Self-checking bench: directed scenarios plus random traffic against a reference model.
module tb_sr_fde_pipeline;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [31:0] pc_i, imAddr, imData, pcPlus4_f_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        branch_d_o;
    logic [31:0] srcA_i, srcB_i;
    logic        wdSrc_o, regWrite_o, branch_o, condZero_o, aluZero_o;
    logic [31:0] aluResult_o, immU_o, pcBranch_o, pcPlus4_o;

    int tests = 0;
    int fails = 0;
    int x3_done = 0;

    sr_fde_pipeline #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .pc_i(pc_i), .imAddr(imAddr),
        .imData(imData), .pcPlus4_f_o(pcPlus4_f_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .branch_d_o(branch_d_o), .srcA_i(srcA_i), .srcB_i(srcB_i),
        .wdSrc_o(wdSrc_o), .regWrite_o(regWrite_o), .branch_o(branch_o),
        .condZero_o(condZero_o), .aluZero_o(aluZero_o), .rd_o(rd_o),
        .aluResult_o(aluResult_o), .immU_o(immU_o), .pcBranch_o(pcBranch_o),
        .pcPlus4_o(pcPlus4_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] alu;
        logic        zero, wd, rw, br, cz;
        logic [4:0]  rd;
        logic [31:0] immu, pcb, pcp4;
    } exp_t;

    // Reference state: what sits in fetch and decode, and expected execute outputs.
    logic [31:0] m_f_instr, m_f_pc, m_d_instr, m_d_pc;
    logic        m_d_kill, m_d_zero;
    exp_t        e;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, rs1, rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, rs2,
                                          input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    // Instruction class: 0 unsupported, 1 add, 2 sub, 3 or, 4 srl, 5 sltu, 6 addi, 7 lui, 8 beq, 9 bne.
    function automatic int classify(input logic [31:0] ins);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        if (op == 7'b0110011) begin
            if (f7 == 7'b0100000 && f3 == 3'b000) return 2;
            if (f7 == 7'b0000000) begin
                if (f3 == 3'b000) return 1;
                if (f3 == 3'b110) return 3;
                if (f3 == 3'b101) return 4;
                if (f3 == 3'b011) return 5;
            end
            return 0;
        end
        if (op == 7'b0010011 && f3 == 3'b000) return 6;
        if (op == 7'b0110111) return 7;
        if (op == 7'b1100011 && f3 == 3'b000) return 8;
        if (op == 7'b1100011 && f3 == 3'b001) return 9;
        return 0;
    endfunction

    function automatic exp_t ref_exec(input logic [31:0] ins, pc, input logic kill, zr,
                                      input logic [31:0] a, b);
        exp_t        r;
        logic [31:0] imm_i, imm_b;
        int          k;
        r = '0;
        r.alu = a + b;
        if (!zr) begin
            imm_i  = {{20{ins[31]}}, ins[31:20]};
            imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            r.rd   = ins[11:7];
            r.immu = {ins[31:12], 12'h000};
            r.pcb  = pc + imm_b;
            r.pcp4 = pc + 32'd4;
            k = kill ? 0 : classify(ins);
            case (k)
                1: begin r.rw = 1; r.wd = 1; r.alu = a + b; end
                2: begin r.rw = 1; r.wd = 1; r.alu = a - b; end
                3: begin r.rw = 1; r.wd = 1; r.alu = a | b; end
                4: begin r.rw = 1; r.wd = 1; r.alu = a >> b[4:0]; end
                5: begin r.rw = 1; r.wd = 1; r.alu = (a < b) ? 32'd1 : 32'd0; end
                6: begin r.rw = 1; r.wd = 1; r.alu = a + imm_i; end
                7: begin r.rw = 1; end
                8: begin r.br = 1; r.cz = 1; r.alu = a - b; end
                9: begin r.br = 1; r.alu = a - b; end
                default: ;
            endcase
        end
        r.zero = (r.alu == 32'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_f_instr = '0;
        m_f_pc    = RPC;
        m_d_instr = '0;
        m_d_pc    = '0;
        m_d_kill  = 1'b0;
        m_d_zero  = 1'b1;
        e         = '0;
    endtask

    task automatic check_all();
        int k;
        k = (m_d_zero || m_d_kill) ? 0 : classify(m_d_instr);
        chk("pcplus4_f", pcPlus4_f_o, m_f_pc + 32'd4);
        chk("rs1", 32'(rs1_o), m_d_zero ? 32'd0 : 32'(m_d_instr[19:15]));
        chk("rs2", 32'(rs2_o), m_d_zero ? 32'd0 : 32'(m_d_instr[24:20]));
        chk("branch_d", 32'(branch_d_o), (k == 8 || k == 9) ? 32'd1 : 32'd0);
        chk("alu_result", aluResult_o, e.alu);
        chk("alu_zero", 32'(aluZero_o), 32'(e.zero));
        chk("wd_src", 32'(wdSrc_o), 32'(e.wd));
        chk("reg_write", 32'(regWrite_o), 32'(e.rw));
        chk("branch", 32'(branch_o), 32'(e.br));
        chk("cond_zero", 32'(condZero_o), 32'(e.cz));
        chk("rd", 32'(rd_o), 32'(e.rd));
        chk("imm_u", immU_o, e.immu);
        chk("pc_branch", pcBranch_o, e.pcb);
        chk("pcplus4_e", pcPlus4_o, e.pcp4);
    endtask

    // One clock: drive inputs, advance the reference at the edge, compare after it.
    task automatic step(input logic [31:0] instr, pc, input logic fz, input logic [31:0] a, b);
        imData = instr; pc_i = pc; freeze = fz; srcA_i = a; srcB_i = b;
        #1;
        chk("im_addr", imAddr, pc);
        @(posedge clk);
        e = ref_exec(m_d_instr, m_d_pc, m_d_kill, m_d_zero, a, b);
        m_d_instr = m_f_instr;
        m_d_pc    = m_f_pc;
        m_d_kill  = fz;
        m_d_zero  = 1'b0;
        if (!fz) begin
            m_f_instr = instr;
            m_f_pc    = pc;
        end
        #1;
        check_all();
        if (regWrite_o && rd_o == 5'd3) x3_done++;
    endtask

    task automatic run3(input logic [31:0] instr, pc, a, b);
        step(instr, pc, 1'b0, 32'd0, 32'd0);
        step(32'd0, pc + 32'd4, 1'b0, 32'd0, 32'd0);
        step(32'd0, pc + 32'd8, 1'b0, a, b);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, r1, r2;
        rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
        case ($urandom_range(0, 11))
            0:  return enc_r(7'b0000000, 3'b000, rd, r1, r2);
            1:  return enc_r(7'b0100000, 3'b000, rd, r1, r2);
            2:  return enc_r(7'b0000000, 3'b110, rd, r1, r2);
            3:  return enc_r(7'b0000000, 3'b101, rd, r1, r2);
            4:  return enc_r(7'b0000000, 3'b011, rd, r1, r2);
            5:  return enc_addi(rd, r1, 12'($urandom));
            6:  return enc_lui(rd, 20'($urandom));
            7:  return enc_b(3'b000, r1, r2, 13'($urandom));
            8:  return enc_b(3'b001, r1, r2, 13'($urandom));
            9:  return $urandom;
            10: return 32'd0;
            default: return enc_r(7'b0100000, 3'b110, rd, r1, r2);
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, held;
        rst = 1'b1; freeze = 1'b0; pc_i = '0; imData = '0; srcA_i = '0; srcB_i = '0;
        model_reset();
        #12;
        chk("rst_pcplus4_f", pcPlus4_f_o, 32'd4);
        chk("rst_reg_write", 32'(regWrite_o), 32'd0);
        chk("rst_alu_result", aluResult_o, 32'd0);
        check_all();
        rst = 1'b0;

        // addi x1,x0,5
        run3(enc_addi(5'd1, 5'd0, 12'd5), 32'd0, 32'd0, 32'd0);
        chk("addi_rw", 32'(regWrite_o), 32'd1);
        chk("addi_wd", 32'(wdSrc_o), 32'd1);
        chk("addi_rd", 32'(rd_o), 32'd1);
        chk("addi_res", aluResult_o, 32'd5);

        // sub 7-7
        run3(enc_r(7'b0100000, 3'b000, 5'd4, 5'd5, 5'd6), 32'd12, 32'd7, 32'd7);
        chk("sub_res", aluResult_o, 32'd0);
        chk("sub_zero", 32'(aluZero_o), 32'd1);

        // sltu 1 < FFFF_FFFF
        run3(enc_r(7'b0000000, 3'b011, 5'd6, 5'd1, 5'd2), 32'd24, 32'd1, 32'hFFFF_FFFF);
        chk("sltu_res", aluResult_o, 32'd1);

        // srl 0x8000_0000 >> 31
        run3(enc_r(7'b0000000, 3'b101, 5'd7, 5'd1, 5'd2), 32'd36, 32'h8000_0000, 32'd31);
        chk("srl_res", aluResult_o, 32'd1);

        // lui x2,0x12345
        run3(enc_lui(5'd2, 20'h12345), 32'd48, 32'd0, 32'd0);
        chk("lui_immu", immU_o, 32'h1234_5000);
        chk("lui_wd", 32'(wdSrc_o), 32'd0);
        chk("lui_rw", 32'(regWrite_o), 32'd1);

        // bne at pc=8, offset -8
        run3(enc_b(3'b001, 5'd1, 5'd2, 13'h1FF8), 32'd8, 32'd3, 32'd4);
        chk("bne_branch", 32'(branch_o), 32'd1);
        chk("bne_cz", 32'(condZero_o), 32'd0);
        chk("bne_pcb", pcBranch_o, 32'd0);

        // Two-cycle freeze while addi x3,x0,9 sits in fetch
        x3_done = 0;
        held = enc_addi(5'd7, 5'd0, 12'd1);
        step(enc_addi(5'd3, 5'd0, 12'd9), 32'd40, 1'b0, 32'd0, 32'd0);
        step(held, 32'd44, 1'b1, 32'd0, 32'd0);
        chk("frz1_pcplus4_f", pcPlus4_f_o, 32'd44);
        step(held, 32'd44, 1'b1, 32'd0, 32'd0);
        chk("frz2_pcplus4_f", pcPlus4_f_o, 32'd44);
        chk("frz_bubble1", 32'(regWrite_o), 32'd0);
        step(held, 32'd44, 1'b0, 32'd0, 32'd0);
        chk("frz_bubble2", 32'(regWrite_o), 32'd0);
        step(32'd0, 32'd48, 1'b0, 32'd0, 32'd0);
        chk("frz_done_rd", 32'(rd_o), 32'd3);
        chk("frz_done_res", aluResult_o, 32'd9);
        for (int i = 0; i < 4; i++) step(32'd0, 32'd52 + 32'(4 * i), 1'b0, 32'd0, 32'd0);
        chk("frz_once", 32'(x3_done), 32'd1);

        // Random traffic with occasional stalls
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            step(rand_instr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 ($urandom_range(0, 6) == 0), a, b);
        end

        // Mid-operation reset flushes everything in flight
        step(enc_addi(5'd5, 5'd1, 12'd3), 32'h100, 1'b0, 32'd1, 32'd2);
        step(enc_lui(5'd6, 20'hABCDE), 32'h104, 1'b0, 32'd1, 32'd2);
        step(enc_r(7'b0000000, 3'b110, 5'd8, 5'd1, 5'd2), 32'h108, 1'b0, 32'd1, 32'd2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("flush_rw", 32'(regWrite_o), 32'd0);
        chk("flush_pcplus4_f", pcPlus4_f_o, 32'd4);
        check_all();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(32'd0, 32'(4 * i), 1'b0, 32'd5, 32'd6);
        chk("flush_no_ghost", 32'(regWrite_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
